rand_matrix_filler: RTL
=======================

// Module: rand_matrix_filler
// PURPOSE
//  Consumer/driver side of the random generator: on start, drives an internal lfsr_core
//  with a latched [min,max] range. Aligns to its en-gated 2-stage pipeline, then streams
//  rows*cols random elements, row-major, into matrix storage through a write port.
//  Feeds the matrix-input path's "random generate" mode.
// PARAMETERS
//  MAX_DIM  5  largest legal rows/cols value
//  DATA_W   8  element width; must equal lfsr_core output width
//  LFSR_LAT 2  en pulses before rand_val reflects the first LFSR state
// PORTS
//  clk      in   1       clock; one clock domain, all logic on posedge clk
//  rst      in   1       asynchronous, active-high reset; also drives lfsr_core rst_n as ~rst
//  start    in   1       1-cycle request; sampled only in IDLE
//  rows_in  in   3       requested row count, 1..MAX_DIM
//  cols_in  in   3       requested column count, 1..MAX_DIM
//  min_in   in   DATA_W  signed lower bound
//  max_in   in   DATA_W  signed upper bound
//  wr_ready in   1       storage can accept a write this cycle
//  wr_en    out  1       element write strobe
//  wr_row   out  3       row index of current write
//  wr_col   out  3       column index of current write
//  wr_data  out  DATA_W  element value, taken directly from lfsr_core rand_val
//  busy     out  1       high in every state except IDLE
//  done     out  1       1-cycle pulse after the last write
//  err      out  1       1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset: state=IDLE; wr_en, wr_row, wr_col, busy, done and err are 0; latched cfg cleared.
//   wr_data follows rand_val, which resets to 0. LFSR state is reset only by rst, never by start.
//  IDLE:
//   - start=1 with rows/cols outside 1..MAX_DIM, or $signed(min_in) > $signed(max_in)
//     -> err=1 for one cycle, stay IDLE.
//   - Otherwise latch rows, cols, min and max -> SETUP.
//  SETUP: 1 cycle, lfsr en=0. Latched min/max are held at lfsr_core cfg inputs for the rest
//   of the operation, and lfsr_core registers range_len during this cycle. -> PRIME.
//  PRIME: lfsr en=1 for exactly LFSR_LAT cycles, no writes. -> FILL.
//  FILL: wr_en = wr_ready; lfsr en = wr_ready (same cycle); no combinational path from
//   wr_ready to any state register.
//   - When wr_ready=0, the lfsr pipeline is frozen and the pending value is held.
//   - On each accepted write, col increments; at cols-1 col wraps to 0 and row increments.
//   - The write at (rows-1, cols-1) -> DONE.
//  DONE: done=1, busy=1 for 1 cycle -> IDLE.
//  Latency (wr_ready always 1): start -> first wr_en = 1+LFSR_LAT+1 = 4 cycles;
//   start -> done = 4 + rows*cols cycles.
//  start while busy is ignored; no error is raised.
//  rst asserted mid-operation aborts immediately to reset values; partial writes already
//   made are not undone.
//  Arithmetic: range and offset are computed inside lfsr_core; wr_data is never modified
//   here. min==max is legal: every element equals min.
// STRUCTURE
//  project_pkg gains:
//   - typedef enum logic [2:0] {GEN_IDLE, GEN_SETUP, GEN_PRIME, GEN_FILL, GEN_DONE} gen_state_t
//   - localparam MAX_DIM = 5 and LFSR_LAT = 2
//  Single sub-module: lfsr_core (clk, rst_n=~rst, en, cfg_min, cfg_max, rand_val).
//  Remainder: state register, prime counter, row/col counters, latched-config registers.
// TESTING
//  T1 rst, then start rows=2 cols=3 min=0 max=127, wr_ready=1 -> writes row-major
//     127,127,126 / 124,120,112 (LFSR FF,FE,FC,F8,F0,E1; offset=raw>>1);
//     first wr_en 4 cycles after start; done 10 cycles after start.
//  T2 as T1 but wr_ready low for 3 cycles after the 2nd write -> wr_en=0 during the stall;
//     identical data sequence; done 3 cycles later than in T1.
//  T3 start rows=0 cols=3; then rows=6; then min=10 max=5 -> err pulse each time, busy stays 0,
//     no wr_en.
//  T4 start min=-3 max=-3 rows=1 cols=1 -> single write, wr_data=8'hFD, done pulse.
//  T5 rst asserted during FILL after 2 writes -> same cycle: wr_en=0, busy=0;
//     a new T1 run reproduces the T1 sequence exactly.
//  T6 second start issued mid-FILL, then a back-to-back run after done -> mid-FILL start is
//     ignored; second run continues the LFSR sequence and does not repeat 127,127,...

Source files
------------

// File: rtl/project_pkg.sv
// Shared types and constants for the random matrix generator.
package project_pkg;

    // Largest legal rows/cols value.
    localparam int unsigned MAX_DIM  = 5;
    // en pulses before lfsr_core rand_val reflects the first LFSR state.
    localparam int unsigned LFSR_LAT = 2;

    typedef enum logic [2:0] {
        GEN_IDLE,
        GEN_SETUP,
        GEN_PRIME,
        GEN_FILL,
        GEN_DONE
    } gen_state_t;

endpackage

// File: rtl/lfsr_core.sv
// Range-scaled LFSR generator with an en-gated 2-stage pipeline:
// stage 1 captures the raw LFSR state, stage 2 maps it into [cfg_min, cfg_max].
module lfsr_core #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] cfg_min,
    input  logic [DATA_W-1:0] cfg_max,
    output logic [DATA_W-1:0] rand_val
);

    logic [DATA_W-1:0]   r_lfsr;
    logic [DATA_W-1:0]   r_raw;
    logic [DATA_W-1:0]   r_rand;
    logic [DATA_W:0]     r_range_len;
    logic [DATA_W:0]     w_range_len;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_offset;
    logic                w_fb;

    // Maximal-length 8-bit taps (8,6,5,4); state shifts left, feedback enters at bit 0.
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // max - min + 1 in one extra bit, so the full signed span (256) is representable.
    assign w_range_len = {cfg_max[DATA_W-1], cfg_max} - {cfg_min[DATA_W-1], cfg_min}
                         + (DATA_W+1)'(1);

    // offset = raw * range_len / 2^DATA_W, always in [0, range_len-1].
    assign w_prod   = {{(DATA_W-1){1'b0}}, r_range_len} * {{DATA_W{1'b0}}, r_raw};
    assign w_offset = DATA_W'(w_prod >> DATA_W);

    // Range length tracks the held config; LFSR and pipeline advance only on en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= '1;
            r_raw       <= '0;
            r_rand      <= '0;
            r_range_len <= '0;
        end else begin
            r_range_len <= w_range_len;
            if (en) begin
                r_lfsr <= {r_lfsr[DATA_W-2:0], w_fb};
                r_raw  <= r_lfsr;
                r_rand <= cfg_min + w_offset;
            end
        end
    end

    assign rand_val = r_rand;

endmodule

// File: rtl/rand_matrix_filler.sv
// Drives lfsr_core with a latched range and streams rows*cols random elements,
// row-major, into matrix storage through a ready-gated write port.
module rand_matrix_filler
    import project_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        rows_in,
    input  logic [2:0]        cols_in,
    input  logic [DATA_W-1:0] min_in,
    input  logic [DATA_W-1:0] max_in,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [2:0]        wr_row,
    output logic [2:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] PRIME_LAST = 2'(LFSR_LAT - 1);

    gen_state_t        r_state, w_state_next;
    logic [1:0]        r_prime_cnt, w_prime_next;
    logic [2:0]        r_row, w_row_next;
    logic [2:0]        r_col, w_col_next;
    logic [2:0]        r_rows, w_rows_next;
    logic [2:0]        r_cols, w_cols_next;
    logic [DATA_W-1:0] r_min, w_min_next;
    logic [DATA_W-1:0] r_max, w_max_next;
    logic              r_err, w_err_next;
    logic              w_cfg_ok;
    logic              w_lfsr_en;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rand_val;

    assign w_cfg_ok = (rows_in != 3'd0) && (rows_in <= 3'(MAX_DIM)) &&
                      (cols_in != 3'd0) && (cols_in <= 3'(MAX_DIM)) &&
                      !($signed(min_in) > $signed(max_in));

    // Next-state, counter and config-latch logic plus LFSR enable.
    always_comb begin
        w_state_next = r_state;
        w_prime_next = r_prime_cnt;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_rows_next  = r_rows;
        w_cols_next  = r_cols;
        w_min_next   = r_min;
        w_max_next   = r_max;
        w_err_next   = 1'b0;
        w_lfsr_en    = 1'b0;
        w_wr_en      = 1'b0;
        unique case (r_state)
            GEN_IDLE: begin
                if (start) begin
                    if (!w_cfg_ok) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_rows_next  = rows_in;
                        w_cols_next  = cols_in;
                        w_min_next   = min_in;
                        w_max_next   = max_in;
                        w_row_next   = 3'd0;
                        w_col_next   = 3'd0;
                        w_prime_next = 2'd0;
                        w_state_next = GEN_SETUP;
                    end
                end
            end
            // lfsr_core captures range_len from the latched config here.
            GEN_SETUP: w_state_next = GEN_PRIME;
            GEN_PRIME: begin
                w_lfsr_en = 1'b1;
                if (r_prime_cnt == PRIME_LAST) begin
                    w_state_next = GEN_FILL;
                end else begin
                    w_prime_next = r_prime_cnt + 2'd1;
                end
            end
            GEN_FILL: begin
                // A stalled write freezes the pipeline so the pending value is kept.
                w_lfsr_en = wr_ready;
                w_wr_en   = wr_ready;
                if (wr_ready) begin
                    if (r_col == r_cols - 3'd1) begin
                        w_col_next = 3'd0;
                        if (r_row == r_rows - 3'd1) begin
                            w_row_next   = 3'd0;
                            w_state_next = GEN_DONE;
                        end else begin
                            w_row_next = r_row + 3'd1;
                        end
                    end else begin
                        w_col_next = r_col + 3'd1;
                    end
                end
            end
            GEN_DONE: w_state_next = GEN_IDLE;
            default:  w_state_next = GEN_IDLE;
        endcase
    end

    // State, counters and latched config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= GEN_IDLE;
            r_prime_cnt <= 2'd0;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_rows      <= 3'd0;
            r_cols      <= 3'd0;
            r_min       <= '0;
            r_max       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prime_cnt <= w_prime_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_rows      <= w_rows_next;
            r_cols      <= w_cols_next;
            r_min       <= w_min_next;
            r_max       <= w_max_next;
            r_err       <= w_err_next;
        end
    end

    lfsr_core #(
        .DATA_W (DATA_W)
    ) u_lfsr_core (
        .clk      (clk),
        .rst_n    (~rst),
        .en       (w_lfsr_en),
        .cfg_min  (r_min),
        .cfg_max  (r_max),
        .rand_val (w_rand_val)
    );

    assign wr_en   = w_wr_en;
    assign wr_row  = r_row;
    assign wr_col  = r_col;
    assign wr_data = w_rand_val;
    assign busy    = (r_state != GEN_IDLE);
    assign done    = (r_state == GEN_DONE);
    assign err     = r_err;

endmodule
